// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Counts pixels/lines in the pixel-clock domain and issues coordinates plus a
// request strobe to the pixel read path. Sync and blank are delayed by the
// read-path latency (PIPE_LAT) so they leave the chip aligned with the colour
// data that comes back for the same coordinate.
// Ports:
//   vgaClk      pixel clock, all logic on its rising edge
//   reset       synchronous, active-high
//   pixIn       {r,g,b} pixel data, valid PIPE_LAT clocks after its pixReq
//   x, y        current horizontal / vertical count
//   pixReq      combinational: current count is inside the visible area
//   frameStart  combinational: current count is (0,0)
//   hSync/vSync sync outputs, aligned to red/green/blue
//   syncB       composite sync to DAC, tied low
//   blankB      1 = active video, aligned to red/green/blue
//   red/green/blue colour outputs, forced to 0 while blanked
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = 2,
    parameter int unsigned PIPE_LAT = 2,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL),
    localparam int unsigned PW      = 3 * COLOR_W
) (
    input  logic               vgaClk,
    input  logic               reset,
    input  logic [PW-1:0]      pixIn,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic               pixReq,
    output logic               frameStart,
    output logic               hSync,
    output logic               vSync,
    output logic               syncB,
    output logic               blankB,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // Inactive {hs, vs, act} used to flush the delay line on reset.
    localparam logic [2:0] IDLE = {~HS_POL, ~VS_POL, 1'b0};

    logic [XW-1:0] hcnt_q, hcnt_d;
    logic [YW-1:0] vcnt_q, vcnt_d;
    logic          h_wrap;
    logic          hs_c, vs_c, act_c;
    logic [2:0]    st0_c;
    logic [2:0]    dly_c;

    logic          hsync_q, vsync_q, blank_q;
    logic [PW-1:0] rgb_q;

    // Raster counters: vertical advances only on the horizontal wrap.
    always_comb begin
        h_wrap = (32'(hcnt_q) == H_TOTAL - 1);
        hcnt_d = h_wrap ? '0 : hcnt_q + XW'(1);
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            vcnt_d = (32'(vcnt_q) == V_TOTAL - 1) ? '0 : vcnt_q + YW'(1);
        end
    end

    always_ff @(posedge vgaClk) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Stage-0 timing decoded straight from the counters.
    always_comb begin
        act_c = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
        hs_c  = ((32'(hcnt_q) >= HS_START) && (32'(hcnt_q) < HS_END)) ? HS_POL : ~HS_POL;
        vs_c  = ((32'(vcnt_q) >= VS_START) && (32'(vcnt_q) < VS_END)) ? VS_POL : ~VS_POL;
        st0_c = {hs_c, vs_c, act_c};
    end

    // Delay line matching the read-path latency; collapses to a wire at 0.
    if (PIPE_LAT == 0) begin : g_nodly
        assign dly_c = st0_c;
    end else begin : g_dly
        logic [2:0] pipe_q [PIPE_LAT];

        always_ff @(posedge vgaClk) begin
            if (reset) begin
                for (int i = 0; i < PIPE_LAT; i++) begin
                    pipe_q[i] <= IDLE;
                end
            end else begin
                pipe_q[0] <= st0_c;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign dly_c = pipe_q[PIPE_LAT-1];
    end

    // Output register; colour is gated by the delayed active flag so blanked
    // pixels never reach the DAC regardless of what the read path returns.
    always_ff @(posedge vgaClk) begin
        if (reset) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hsync_q <= dly_c[2];
            vsync_q <= dly_c[1];
            blank_q <= dly_c[0];
            rgb_q   <= dly_c[0] ? pixIn : '0;
        end
    end

    assign x          = hcnt_q;
    assign y          = vcnt_q;
    assign pixReq     = act_c;
    assign frameStart = (hcnt_q == '0) && (vcnt_q == '0);
    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign syncB      = 1'b0;
    assign blankB     = blank_q;
    assign red        = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign green      = rgb_q[2*COLOR_W-1:COLOR_W];
    assign blue       = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small raster:
// H 4/1/2/1 (8 clocks/line), V 3/1/1/1 (6 lines/frame), PIPE_LAT=2, COLOR_W=2.
// A second instance with HS_POL=1 shares all inputs.
module tb_vga_timing_gen;

    logic       vgaClk = 1'b0;
    logic       reset  = 1'b1;
    logic [5:0] pixIn  = '0;

    logic [2:0] x, y;
    logic       pixReq, frameStart, hSync, vSync, syncB, blankB;
    logic [1:0] red, green, blue;

    logic [2:0] p_x, p_y;
    logic       p_pixReq, p_frameStart, p_hSync, p_vSync, p_syncB, p_blankB;
    logic [1:0] p_red, p_green, p_blue;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(2), .PIPE_LAT(2)
    ) dut (
        .vgaClk(vgaClk), .reset(reset), .pixIn(pixIn),
        .x(x), .y(y), .pixReq(pixReq), .frameStart(frameStart),
        .hSync(hSync), .vSync(vSync), .syncB(syncB), .blankB(blankB),
        .red(red), .green(green), .blue(blue)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(2), .PIPE_LAT(2)
    ) dut_p (
        .vgaClk(vgaClk), .reset(reset), .pixIn(pixIn),
        .x(p_x), .y(p_y), .pixReq(p_pixReq), .frameStart(p_frameStart),
        .hSync(p_hSync), .vSync(p_vSync), .syncB(p_syncB), .blankB(p_blankB),
        .red(p_red), .green(p_green), .blue(p_blue)
    );

    always #5 vgaClk = ~vgaClk;

    int         n;          // clocks since reset release; n==0 is count (0,0)
    int         vectors;
    int         errors;
    bit         force_ff;
    logic [5:0] prev_pix;   // pixIn as sampled at the most recent edge

    // Read-path model: {x[1:0], y[1:0], x[1:0]} for the count at clock c.
    function automatic logic [5:0] pattern(input int c);
        logic [2:0] hx, vy;
        if (c < 0) return 6'h00;
        hx = 3'(c % 8);
        vy = 3'((c / 8) % 6);
        return {hx[1:0], vy[1:0], hx[1:0]};
    endfunction

    // Expected pin values at clock c: they reflect the count of clock c-3.
    function automatic logic exp_hs(input int c, input logic pol);
        int m = c - 3;
        if (m < 0) return ~pol;
        return ((m % 8) == 5 || (m % 8) == 6) ? pol : ~pol;
    endfunction

    function automatic logic exp_vs(input int c);
        int m = c - 3;
        if (m < 0) return 1'b1;
        return (((m / 8) % 6) == 4) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_blank(input int c);
        int m = c - 3;
        if (m < 0) return 1'b0;
        return ((m % 8) < 4) && (((m / 8) % 6) < 3);
    endfunction

    task automatic step();
        prev_pix = pixIn;
        @(posedge vgaClk);
        #1;
        n++;
        pixIn = force_ff ? 6'h3F : pattern(n - 2);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        force_ff = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({x, y} !== 6'h00) begin
                errors++; $display("FAIL reset_xy got=%h exp=00", {x, y});
            end
            vectors++;
            if ({hSync, vSync, blankB, syncB} !== 4'b1100) begin
                errors++; $display("FAIL reset_sync got=%b exp=1100", {hSync, vSync, blankB, syncB});
            end
            vectors++;
            if ({red, green, blue} !== 6'h00) begin
                errors++; $display("FAIL reset_rgb got=%h exp=00", {red, green, blue});
            end
            vectors++;
            if ({pixReq, frameStart} !== 2'b11) begin
                errors++; $display("FAIL reset_req got=%b exp=11", {pixReq, frameStart});
            end
            vectors++;
            if (p_hSync !== 1'b0) begin
                errors++; $display("FAIL reset_hs_pol1 got=%b exp=0", p_hSync);
            end
        end
        reset = 1'b0;
        n     = 0;
        pixIn = pattern(-2);
    endtask

    // Counters, request strobes and sync/blank placement over two frames.
    task automatic test_timing();
        int hs_low = 0;
        int vs_low = 0;
        for (int k = 0; k < 100; k++) begin
            vectors++;
            if (x !== 3'(n % 8) || y !== 3'((n / 8) % 6)) begin
                errors++; $display("FAIL cnt n=%0d got=%0d,%0d exp=%0d,%0d", n, x, y, n % 8, (n / 8) % 6);
            end
            vectors++;
            if (pixReq !== (((n % 8) < 4) && (((n / 8) % 6) < 3))) begin
                errors++; $display("FAIL pixreq n=%0d got=%b", n, pixReq);
            end
            vectors++;
            if (frameStart !== ((n % 48) == 0)) begin
                errors++; $display("FAIL framestart n=%0d got=%b", n, frameStart);
            end
            vectors++;
            if (hSync !== exp_hs(n, 1'b0) || p_hSync !== exp_hs(n, 1'b1)) begin
                errors++; $display("FAIL hsync n=%0d got=%b/%b exp=%b/%b", n, hSync, p_hSync, exp_hs(n, 1'b0), exp_hs(n, 1'b1));
            end
            vectors++;
            if (vSync !== exp_vs(n) || blankB !== exp_blank(n)) begin
                errors++; $display("FAIL vs_blank n=%0d got=%b%b exp=%b%b", n, vSync, blankB, exp_vs(n), exp_blank(n));
            end
            if (n >= 3 && n < 51) begin
                if (hSync == 1'b0) hs_low++;
                if (vSync == 1'b0) vs_low++;
            end
            step();
        end
        vectors++;
        if (hs_low !== 12) begin
            errors++; $display("FAIL hs_low_count got=%0d exp=12", hs_low);
        end
        vectors++;
        if (vs_low !== 8) begin
            errors++; $display("FAIL vs_low_count got=%0d exp=8", vs_low);
        end
    endtask

    // Returned pixel data lands on the pins together with its blank window.
    task automatic test_pixel();
        logic [5:0] exp_rgb;
        force_ff = 1'b0;
        for (int k = 0; k < 48; k++) begin
            exp_rgb = exp_blank(n) ? pattern(n - 3) : 6'h00;
            vectors++;
            if ({red, green, blue} !== exp_rgb || prev_pix !== pattern(n - 3)) begin
                errors++; $display("FAIL pixel n=%0d got=%h exp=%h", n, {red, green, blue}, exp_rgb);
            end
            step();
        end
    endtask

    // Constant full-scale input must only appear inside the active window.
    task automatic test_blank_leak();
        int active = 0;
        force_ff = 1'b1;
        pixIn    = 6'h3F;
        step();
        for (int k = 0; k < 48; k++) begin
            vectors++;
            if ({red, green, blue} !== (blankB ? 6'h3F : 6'h00) || blankB !== exp_blank(n)) begin
                errors++; $display("FAIL blank_leak n=%0d got=%h blankB=%b", n, {red, green, blue}, blankB);
            end
            if (blankB) active++;
            step();
        end
        vectors++;
        if (active !== 12) begin
            errors++; $display("FAIL active_count got=%0d exp=12", active);
        end
        force_ff = 1'b0;
        pixIn    = pattern(n - 2);
        step();
    endtask

    // One-clock reset in mid-frame restarts the raster cleanly at (0,0).
    task automatic test_mid_reset();
        for (int k = 0; k < 48 && (n % 48) != 19; k++) step();
        vectors++;
        if (x !== 3'd3 || y !== 3'd2) begin
            errors++; $display("FAIL mid_pos got=%0d,%0d exp=3,2", x, y);
        end
        reset = 1'b1;
        step();
        vectors++;
        if ({x, y} !== 6'h00 || {hSync, vSync, blankB} !== 3'b110 || {red, green, blue} !== 6'h00) begin
            errors++; $display("FAIL mid_reset got=%h %b %h", {x, y}, {hSync, vSync, blankB}, {red, green, blue});
        end
        vectors++;
        if (p_hSync !== 1'b0) begin
            errors++; $display("FAIL mid_reset_pol1 got=%b exp=0", p_hSync);
        end
        reset = 1'b0;
        n     = 0;
        pixIn = pattern(-2);
        for (int k = 0; k < 60; k++) begin
            vectors++;
            if (x !== 3'(n % 8) || y !== 3'((n / 8) % 6)) begin
                errors++; $display("FAIL restart_cnt n=%0d got=%0d,%0d", n, x, y);
            end
            vectors++;
            if (hSync !== exp_hs(n, 1'b0) || p_hSync !== exp_hs(n, 1'b1) || vSync !== exp_vs(n) || blankB !== exp_blank(n)) begin
                errors++; $display("FAIL restart_sync n=%0d got=%b%b%b%b", n, hSync, p_hSync, vSync, blankB);
            end
            step();
        end
    endtask

    initial begin
        n        = 0;
        vectors  = 0;
        errors   = 0;
        force_ff = 1'b0;
        prev_pix = '0;
        test_reset();
        test_timing();
        test_pixel();
        test_blank_leak();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
